// File: rtl/vec_pack_wb.sv
// Writeback packer: gathers TPW consecutive Q8.8 tiles into one output word and
// writes it to the vector buffer at a generated, wrapping address.
module vec_pack_wb #(
   parameter int unsigned TILE_SIZE  = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned D          = 256,
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned N_VEC      = 64,
   parameter int unsigned OUT_ADDR_W = 10,
   localparam int unsigned TileW     = TILE_SIZE * DATA_WIDTH,
   localparam int unsigned Tpw       = DATA_W / TileW,
   localparam int unsigned Wpv       = D * DATA_WIDTH / DATA_W,
   localparam int unsigned SlotW     = (Tpw > 1) ? $clog2(Tpw) : 1,
   localparam int unsigned WordW     = (Wpv > 1) ? $clog2(Wpv) : 1,
   localparam int unsigned VecW      = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       clr,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] in_vec,
   output logic                                       wr_valid,
   input  logic                                       wr_ready,
   output logic [OUT_ADDR_W-1:0]                      wr_addr,
   output logic [DATA_W-1:0]                          wr_data,
   output logic                                       vec_done,
   output logic [VecW-1:0]                            vec_idx,
   output logic                                       busy
);

   logic [SlotW-1:0]            tile_slot_q, tile_slot_d;
   logic [WordW-1:0]            word_cnt_q, word_cnt_d;
   logic [VecW-1:0]             vec_cnt_q, vec_cnt_d;
   logic [Tpw-2:0][TileW-1:0]   stage_q, stage_d;
   logic                        wr_valid_q, wr_valid_d;
   logic [OUT_ADDR_W-1:0]       wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]           wr_data_q, wr_data_d;
   logic                        wr_last_q, wr_last_d;
   logic [VecW-1:0]             wr_vec_q, wr_vec_d;
   logic                        vec_done_q, vec_done_d;
   logic [VecW-1:0]             vec_idx_q, vec_idx_d;

   logic accept, commit, drain, last_slot, last_word, last_vec;

   assign last_slot = (tile_slot_q == SlotW'(Tpw - 1));
   assign last_word = (word_cnt_q == WordW'(Wpv - 1));
   assign last_vec  = (vec_cnt_q == VecW'(N_VEC - 1));

   // The final tile bypasses staging, so it may only enter if the output register frees up.
   assign in_ready = !last_slot || !wr_valid_q || wr_ready;
   assign accept   = in_valid && in_ready;
   assign commit   = accept && last_slot;
   assign drain    = wr_valid_q && wr_ready;

   always_comb begin
      tile_slot_d = tile_slot_q;
      word_cnt_d  = word_cnt_q;
      vec_cnt_d   = vec_cnt_q;
      stage_d     = stage_q;
      if (accept) begin
         if (last_slot) begin
            tile_slot_d = '0;
            word_cnt_d  = last_word ? '0 : word_cnt_q + WordW'(1);
            if (last_word) begin
               vec_cnt_d = last_vec ? '0 : vec_cnt_q + VecW'(1);
            end
         end else begin
            stage_d[tile_slot_q] = in_vec;
            tile_slot_d          = tile_slot_q + SlotW'(1);
         end
      end
   end

   // A commit in the same cycle as a drain simply reloads, keeping wr_valid high.
   always_comb begin
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_last_d  = wr_last_q;
      wr_vec_d   = wr_vec_q;
      if (commit) begin
         wr_valid_d = 1'b1;
         wr_data_d  = {in_vec, stage_q};
         wr_addr_d  = OUT_ADDR_W'(32'(vec_cnt_q) * Wpv + 32'(word_cnt_q));
         wr_last_d  = last_word;
         wr_vec_d   = vec_cnt_q;
      end else if (drain) begin
         wr_valid_d = 1'b0;
      end
   end

   always_comb begin
      vec_done_d = drain && wr_last_q;
      vec_idx_d  = vec_idx_q;
      if (vec_done_d) begin
         vec_idx_d = wr_vec_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_slot_q <= '0;
         word_cnt_q  <= '0;
         vec_cnt_q   <= '0;
         stage_q     <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_last_q   <= 1'b0;
         wr_vec_q    <= '0;
         vec_done_q  <= 1'b0;
         vec_idx_q   <= '0;
      end else if (clr) begin
         tile_slot_q <= '0;
         word_cnt_q  <= '0;
         vec_cnt_q   <= '0;
         stage_q     <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_last_q   <= 1'b0;
         wr_vec_q    <= '0;
         vec_done_q  <= 1'b0;
         vec_idx_q   <= '0;
      end else begin
         tile_slot_q <= tile_slot_d;
         word_cnt_q  <= word_cnt_d;
         vec_cnt_q   <= vec_cnt_d;
         stage_q     <= stage_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_last_q   <= wr_last_d;
         wr_vec_q    <= wr_vec_d;
         vec_done_q  <= vec_done_d;
         vec_idx_q   <= vec_idx_d;
      end
   end

   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign vec_done = vec_done_q;
   assign vec_idx  = vec_idx_q;
   assign busy     = (tile_slot_q != '0) || (word_cnt_q != '0) || wr_valid_q;

endmodule

// File: tb/tb_vec_pack_wb.sv
// Randomized bench for vec_pack_wb against a lane-queue reference model.
module tb_vec_pack_wb;

   localparam int NW = 1024;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     clr = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     wr_ready = 1'b0;
   logic signed [3:0][15:0]  in_vec;
   logic                     in_ready, wr_valid, vec_done, busy;
   logic [9:0]               wr_addr;
   logic [255:0]             wr_data;
   logic [5:0]               vec_idx;

   vec_pack_wb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_vec   (in_vec),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .vec_done (vec_done),
      .vec_idx  (vec_idx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: every accepted lane in arrival order; 16 lanes make one word.
   int           n_tiles;
   int           n_written;
   logic [15:0]  lanes_q[$];
   logic [255:0] exp_q[$];
   bit           done_exp;
   int           last_idx;
   bit           acc_g;

   task automatic model_reset();
      n_tiles   = 0;
      n_written = 0;
      lanes_q.delete();
      exp_q.delete();
      done_exp  = 0;
      last_idx  = 0;
   endtask

   // One cycle: check outputs at the falling edge, advance the model, return after the rising edge.
   task automatic step();
      int           slot, outst;
      bit           exp_rdy, wfire;
      logic [255:0] word;
      @(negedge clk);
      slot    = n_tiles % 4;
      outst   = n_tiles / 4 - n_written;
      exp_rdy = !(slot == 3 && outst != 0 && !wr_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("wr_valid", wr_valid, outst != 0);
      chk("busy", busy, slot != 0 || (n_tiles / 4) % 16 != 0 || outst != 0);
      chk("vec_done", vec_done, done_exp);
      chk("vec_idx", vec_idx, last_idx);
      if (outst != 0 && exp_q.size() > 0) begin
         chk("wr_addr", wr_addr, n_written % NW);
         chk("wr_data", wr_data, exp_q[0]);
      end
      acc_g = 0;
      if (clr) begin
         model_reset();
      end else begin
         wfire    = (outst != 0) && wr_ready;
         done_exp = wfire && (n_written % 16 == 15);
         if (done_exp) last_idx = (n_written / 16) % 64;
         if (in_valid && exp_rdy) begin
            acc_g = 1;
            for (int i = 0; i < 4; i++) lanes_q.push_back(in_vec[i]);
            n_tiles++;
            if (lanes_q.size() == 16) begin
               for (int j = 0; j < 16; j++) word[j*16 +: 16] = lanes_q.pop_front();
               exp_q.push_back(word);
            end
         end
         if (wfire) begin
            void'(exp_q.pop_front());
            n_written++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 0;
      in_vec   = 'x;
      wr_ready = 1;
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr_valid"}, wr_valid, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_vec_done"}, vec_done, 0);
      chk({tag, "_vec_idx"}, vec_idx, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int t, sent;
      logic [15:0] ext [4];
      ext[0] = 16'hFFFF; ext[1] = 16'h8000; ext[2] = 16'h7FFF; ext[3] = 16'h0100;
      in_vec = 'x;
      model_reset();
      #12;
      check_all_zero("reset");
      rst_n = 1;
      @(posedge clk);
      #1;

      // Sequential lanes 1000+4t+i at full rate.
      t = 0;
      wr_ready = 1;
      for (int c = 0; c < 200 && t < 64; c++) begin
         in_valid = 1;
         for (int i = 0; i < 4; i++) in_vec[i] = 16'(1000 + 4 * t + i);
         step();
         if (acc_g) t++;
      end
      chk("seq_tiles", t, 64);
      idle(4);

      // Backpressure: output stalled while the next word assembles.
      sent = 0;
      for (int c = 0; c < 40; c++) begin
         wr_ready = (c >= 12);
         in_valid = (sent < 8);
         for (int i = 0; i < 4; i++) in_vec[i] = 16'(2000 + 4 * sent + i);
         step();
         if (acc_g) sent++;
      end
      chk("bp_tiles", sent, 8);
      idle(4);

      // Random traffic long enough to wrap the whole buffer.
      for (int c = 0; c < 20000 && n_tiles < 4200; c++) begin
         in_valid = ($urandom_range(0, 9) != 0);
         wr_ready = ($urandom_range(0, 4) != 0);
         if (in_valid) for (int i = 0; i < 4; i++) in_vec[i] = 16'($urandom);
         else in_vec = 'x;
         step();
      end
      chk("rand_tiles_done", n_tiles >= 4200, 1);
      idle(4);

      // Soft clear after two tiles, then one word of sevens.
      wr_ready = 1;
      sent = 0;
      for (int c = 0; c < 10 && sent < 2; c++) begin
         in_valid = 1;
         for (int i = 0; i < 4; i++) in_vec[i] = 16'(3000 + i);
         step();
         if (acc_g) sent++;
      end
      in_valid = 0;
      clr = 1;
      step();
      clr = 0;
      chk("clr_busy", busy, 0);
      sent = 0;
      for (int c = 0; c < 10 && sent < 4; c++) begin
         in_valid = 1;
         for (int i = 0; i < 4; i++) in_vec[i] = 16'd7;
         step();
         if (acc_g) sent++;
      end
      idle(3);

      // Async reset while word 5 is pending.
      for (int c = 0; c < 200; c++) begin
         in_valid = (n_tiles < 24);
         wr_ready = (n_written < 5);
         for (int i = 0; i < 4; i++) in_vec[i] = 16'($urandom);
         step();
         if (n_written == 5 && n_tiles >= 24) break;
      end
      chk("pre_rst_wr_valid", wr_valid, (n_tiles / 4 - n_written) != 0);
      chk("pre_rst_wr_addr", wr_addr, 5);
      in_valid = 0;
      #2 rst_n = 0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk);
      #1;
      sent = 0;
      wr_ready = 1;
      for (int c = 0; c < 10 && sent < 4; c++) begin
         in_valid = 1;
         for (int i = 0; i < 4; i++) in_vec[i] = 16'(4000 + 4 * sent + i);
         step();
         if (acc_g) sent++;
      end
      idle(3);

      // Extreme bit patterns, with idle X cycles in between.
      sent = 0;
      for (int c = 0; c < 20 && sent < 4; c++) begin
         in_valid = c[0];
         if (in_valid) for (int i = 0; i < 4; i++) in_vec[i] = ext[(i + sent) % 4];
         else in_vec = 'x;
         step();
         if (acc_g) sent++;
      end
      idle(4);
      chk("drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
